// File: rtl/tpg_pkg.sv
// Shared definitions for the test-pattern generator.
//   - tpg_mode_t : pattern select encoding (CHECKER/BARS/RAMP/GRID)
//   - NUM_BARS   : number of vertical bars in the BARS pattern
//   - bar_bound  : first column of bar k (elaboration-time constant)
//   - bar_level  : grey level of bar k, floor(k*MAX/(NUM_BARS-1))
package tpg_pkg;

    typedef enum logic [1:0] {
        CHECKER = 2'd0,
        BARS    = 2'd1,
        RAMP    = 2'd2,
        GRID    = 2'd3
    } tpg_mode_t;

    localparam int NUM_BARS  = 8;
    localparam int BAR_IDX_W = 3;

    // Left edge of bar k for a line of h_active pixels.
    function automatic int bar_bound(input int k, input int h_active);
        return (k * h_active) / NUM_BARS;
    endfunction

    // Grey level of bar k: evenly spread from 0 to full scale.
    function automatic int bar_level(input int k, input int pix_w);
        return (k * ((1 << pix_w) - 1)) / (NUM_BARS - 1);
    endfunction

endpackage

// File: rtl/tpg_frame_ctrl.sv
// Frame-level control for the test-pattern generator.
// Detects the frame-start pixel, latches the pattern mode, accumulates the
// scroll offset and counts frames. Mode and offset are forwarded through a
// bypass so the frame-start pixel itself already uses the new values.
//
// Ports:
//   clk, rst_n   : pixel clock, synchronous active-low reset
//   vga_x, vga_y : current pixel coordinates
//   de_in        : active-video qualifier
//   mode_in      : requested pattern (sampled only at frame start)
//   scroll_en    : advance offset by SCROLL_STEP at frame start
//   mode_eff     : mode in force for the current pixel
//   off_eff      : low OFF_W bits of the offset in force for the current pixel
//   frame_cnt    : frame starts seen since reset, modulo 256
module tpg_frame_ctrl
    import tpg_pkg::*;
#(
    parameter int COORD_W     = 11,
    parameter int OFF_W       = 8,
    parameter int SCROLL_STEP = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] vga_x,
    input  logic [COORD_W-1:0] vga_y,
    input  logic               de_in,
    input  logic [1:0]         mode_in,
    input  logic               scroll_en,
    output tpg_mode_t          mode_eff,
    output logic [OFF_W-1:0]   off_eff,
    output logic [7:0]         frame_cnt
);

    localparam logic [COORD_W-1:0] STEP_C = COORD_W'(SCROLL_STEP);

    tpg_mode_t          mode_reg;
    logic [COORD_W-1:0] off_reg;
    logic [COORD_W-1:0] off_next;
    logic [7:0]         frame_cnt_reg;
    logic               fs;

    assign fs = de_in && (vga_x == '0) && (vga_y == '0);

    // Offset that applies from this frame start onward; wraps naturally.
    always_comb begin
        off_next = off_reg;
        if (fs && scroll_en) begin
            off_next = off_reg + STEP_C;
        end
    end

    // Bypass: the frame-start pixel sees the freshly selected mode/offset.
    assign mode_eff  = fs ? tpg_mode_t'(mode_in) : mode_reg;
    assign off_eff   = off_next[OFF_W-1:0];
    assign frame_cnt = frame_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_reg      <= CHECKER;
            off_reg       <= '0;
            frame_cnt_reg <= '0;
        end else if (fs) begin
            mode_reg      <= tpg_mode_t'(mode_in);
            off_reg       <= off_next;
            frame_cnt_reg <= frame_cnt_reg + 8'd1;
        end
    end

endmodule

// File: rtl/test_pattern_gen.sv
// Multi-mode greyscale test-pattern generator for the VGA debug path.
// Two-stage pipeline: stage 1 captures the scrolled column, bar index,
// validity, mode and the row-derived flags; stage 2 produces the pixel.
//
// Ports:
//   clk, rst_n   : pixel clock, synchronous active-low reset
//   vga_x, vga_y : pixel coordinates from the timing generator
//   de_in        : active-video qualifier
//   mode_in      : 0 CHECKER, 1 BARS, 2 RAMP, 3 GRID (applied at frame start)
//   scroll_en    : per-frame horizontal scroll enable (applied at frame start)
//   pixel_out    : generated pixel, 2 cycles after the inputs
//   de_out       : de_in delayed by 2 cycles
//   frame_cnt    : frame starts seen, modulo 256
module test_pattern_gen
    import tpg_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int COORD_W     = 11,
    parameter int PIX_W       = 8,
    parameter int CELL_LOG2   = 5,
    parameter int SCROLL_STEP = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] vga_x,
    input  logic [COORD_W-1:0] vga_y,
    input  logic               de_in,
    input  logic [1:0]         mode_in,
    input  logic               scroll_en,
    output logic [PIX_W-1:0]   pixel_out,
    output logic               de_out,
    output logic [7:0]         frame_cnt
);

    // Only the low column bits reach any pattern, so only those are carried.
    localparam int XS_W = (PIX_W > CELL_LOG2 + 1) ? PIX_W : CELL_LOG2 + 1;

    localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] H_LAST_C = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] V_LAST_C = COORD_W'(V_ACTIVE - 1);
    localparam logic [PIX_W-1:0]   PIX_MAX  = '1;

    tpg_mode_t        mode_eff;
    logic [XS_W-1:0]  off_eff;
    logic [XS_W-1:0]  xs;
    logic             valid;
    logic             y_cell_bit;
    logic             y_line;
    logic             edge_line;

    logic [NUM_BARS-1:0]  bar_ge;
    logic [BAR_IDX_W-1:0] bar_idx;
    logic [PIX_W-1:0]     bar_lvl [NUM_BARS];

    // Stage 1 registers
    logic [XS_W-1:0]      xs_reg;
    logic [BAR_IDX_W-1:0] bar_idx_reg;
    logic                 valid_reg;
    tpg_mode_t            mode_reg;
    logic                 y_cell_bit_reg;
    logic                 y_line_reg;
    logic                 edge_reg;
    logic                 de1_reg;

    // Stage 2 registers
    logic [PIX_W-1:0]     pixel_next;
    logic [PIX_W-1:0]     pixel_reg;
    logic                 de2_reg;

    tpg_frame_ctrl #(
        .COORD_W     (COORD_W),
        .OFF_W       (XS_W),
        .SCROLL_STEP (SCROLL_STEP)
    ) u_frame_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .de_in     (de_in),
        .mode_in   (mode_in),
        .scroll_en (scroll_en),
        .mode_eff  (mode_eff),
        .off_eff   (off_eff),
        .frame_cnt (frame_cnt)
    );

    // ---------------- Stage 1 combinational ----------------
    assign xs         = vga_x[XS_W-1:0] + off_eff;
    assign valid      = de_in && (vga_x < H_ACT_C) && (vga_y < V_ACT_C);
    assign y_cell_bit = vga_y[CELL_LOG2];
    assign y_line     = (vga_y[CELL_LOG2-1:0] == '0);
    assign edge_line  = (vga_x == H_LAST_C) || (vga_y == V_LAST_C);

    // Bar boundaries and levels are fixed comparators/constants per bar.
    assign bar_ge[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < NUM_BARS; gi++) begin : g_bar_cmp
            localparam logic [COORD_W-1:0] BOUND = COORD_W'(bar_bound(gi, H_ACTIVE));
            assign bar_ge[gi] = (vga_x >= BOUND);
        end
        for (genvar gi = 0; gi < NUM_BARS; gi++) begin : g_bar_lvl
            assign bar_lvl[gi] = PIX_W'(bar_level(gi, PIX_W));
        end
    endgenerate

    // Boundaries are ascending, so the highest set comparator is the bar.
    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < NUM_BARS; k++) begin
            if (bar_ge[k]) begin
                bar_idx = BAR_IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xs_reg         <= '0;
            bar_idx_reg    <= '0;
            valid_reg      <= 1'b0;
            mode_reg       <= CHECKER;
            y_cell_bit_reg <= 1'b0;
            y_line_reg     <= 1'b0;
            edge_reg       <= 1'b0;
            de1_reg        <= 1'b0;
        end else begin
            xs_reg         <= xs;
            bar_idx_reg    <= bar_idx;
            valid_reg      <= valid;
            mode_reg       <= mode_eff;
            y_cell_bit_reg <= y_cell_bit;
            y_line_reg     <= y_line;
            edge_reg       <= edge_line;
            de1_reg        <= de_in;
        end
    end

    // ---------------- Stage 2 combinational ----------------
    always_comb begin
        pixel_next = '0;
        if (valid_reg) begin
            case (mode_reg)
                CHECKER: pixel_next = (xs_reg[CELL_LOG2] ^ y_cell_bit_reg) ? PIX_MAX : '0;
                BARS:    pixel_next = bar_lvl[bar_idx_reg];
                RAMP:    pixel_next = xs_reg[PIX_W-1:0];
                GRID:    pixel_next = ((xs_reg[CELL_LOG2-1:0] == '0) || y_line_reg || edge_reg)
                                      ? PIX_MAX : '0;
                default: pixel_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_reg <= '0;
            de2_reg   <= 1'b0;
        end else begin
            pixel_reg <= pixel_next;
            de2_reg   <= de1_reg;
        end
    end

    assign pixel_out = pixel_reg;
    assign de_out    = de2_reg;

endmodule

// File: tb/tb_test_pattern_gen.sv
module tb_test_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] vga_x;
    logic [10:0] vga_y;
    logic        de_in;
    logic [1:0]  mode_in;
    logic        scroll_en;
    logic [7:0]  pixel_out;
    logic        de_out;
    logic [7:0]  frame_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    test_pattern_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .de_in     (de_in),
        .mode_in   (mode_in),
        .scroll_en (scroll_en),
        .pixel_out (pixel_out),
        .de_out    (de_out),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        vga_x = '0;
        vga_y = '0;
        de_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Present one pixel, then idle, and return the outputs 2 cycles later.
    task automatic pix(input int x, input int y, input logic de,
                       output logic [7:0] p, output logic d);
        vga_x = 11'(x);
        vga_y = 11'(y);
        de_in = de;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        p = pixel_out;
        d = de_out;
        $display("pixel x=%0d y=%0d de=%0b mode=%0d scroll=%0b -> pixel_out=%0d de_out=%0b frame_cnt=%0d",
                 x, y, de, mode_in, scroll_en, p, d, frame_cnt);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mode_in   = 2'd0;
        scroll_en = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (pixel_out !== 8'd0) $display("FAIL reset_pixel: got %0d want 0", pixel_out);
        else pass_cnt++;
        total_cnt++;
        if (de_out !== 1'b0) $display("FAIL reset_de: got %0b want 0", de_out);
        else pass_cnt++;
        total_cnt++;
        if (frame_cnt !== 8'd0) $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_checker();
        logic [7:0] p;
        logic       d;
        do_reset();
        mode_in = 2'd0; scroll_en = 1'b0;
        pix(0, 0, 1'b1, p, d);
        total_cnt++;
        if (p !== 8'h00) $display("FAIL checker_0_0: got %0d want 0", p);
        else pass_cnt++;
        pix(32, 0, 1'b1, p, d);
        total_cnt++;
        if (p !== 8'hFF) $display("FAIL checker_32_0: got %0d want 255", p);
        else pass_cnt++;
        pix(32, 32, 1'b1, p, d);
        total_cnt++;
        if (p !== 8'h00) $display("FAIL checker_32_32: got %0d want 0", p);
        else pass_cnt++;
        total_cnt++;
        if (frame_cnt !== 8'd1) $display("FAIL checker_frame_cnt: got %0d want 1", frame_cnt);
        else pass_cnt++;
    endtask

    task automatic test_scroll();
        logic [7:0] p;
        logic       d;
        do_reset();
        mode_in = 2'd0; scroll_en = 1'b1;
        for (int i = 0; i < 3; i++) pix(0, 0, 1'b1, p, d);
        total_cnt++;
        if (frame_cnt !== 8'd3) $display("FAIL scroll_frame_cnt: got %0d want 3", frame_cnt);
        else pass_cnt++;
        // off = 12, so column 20 maps to xs = 32
        pix(20, 0, 1'b1, p, d);
        total_cnt++;
        if (p !== 8'hFF) $display("FAIL scroll_checker_20_0: got %0d want 255", p);
        else pass_cnt++;
        scroll_en = 1'b0;
    endtask

    task automatic test_bars();
        logic [7:0] p;
        logic       d;
        do_reset();
        mode_in = 2'd1; scroll_en = 1'b0;
        pix(0, 0, 1'b1, p, d);
        pix(79, 3, 1'b1, p, d);
        total_cnt++;
        if (p !== 8'd0) $display("FAIL bars_x79: got %0d want 0", p);
        else pass_cnt++;
        pix(80, 3, 1'b1, p, d);
        total_cnt++;
        if (p !== 8'd36) $display("FAIL bars_x80: got %0d want 36", p);
        else pass_cnt++;
        total_cnt++;
        if (d !== 1'b1) $display("FAIL bars_de_high: got %0b want 1", d);
        else pass_cnt++;
        pix(639, 3, 1'b1, p, d);
        total_cnt++;
        if (p !== 8'd255) $display("FAIL bars_x639: got %0d want 255", p);
        else pass_cnt++;
        pix(700, 3, 1'b1, p, d);
        total_cnt++;
        if (p !== 8'd0) $display("FAIL bars_x700: got %0d want 0", p);
        else pass_cnt++;
        pix(400, 3, 1'b0, p, d);
        total_cnt++;
        if (d !== 1'b0 || p !== 8'd0) $display("FAIL bars_de_low: got de=%0b pix=%0d want de=0 pix=0", d, p);
        else pass_cnt++;
    endtask

    task automatic test_ramp_grid();
        logic [7:0] p;
        logic       d;
        do_reset();
        mode_in = 2'd2; scroll_en = 1'b0;
        pix(0, 0, 1'b1, p, d);
        pix(300, 7, 1'b1, p, d);
        total_cnt++;
        if (p !== 8'h2C) $display("FAIL ramp_x300: got %0d want 44", p);
        else pass_cnt++;
        do_reset();
        mode_in = 2'd3;
        pix(0, 0, 1'b1, p, d);
        pix(64, 5, 1'b1, p, d);
        total_cnt++;
        if (p !== 8'hFF) $display("FAIL grid_64_5: got %0d want 255", p);
        else pass_cnt++;
        pix(65, 5, 1'b1, p, d);
        total_cnt++;
        if (p !== 8'h00) $display("FAIL grid_65_5: got %0d want 0", p);
        else pass_cnt++;
        pix(639, 5, 1'b1, p, d);
        total_cnt++;
        if (p !== 8'hFF) $display("FAIL grid_639_5: got %0d want 255", p);
        else pass_cnt++;
        pix(65, 479, 1'b1, p, d);
        total_cnt++;
        if (p !== 8'hFF) $display("FAIL grid_65_479: got %0d want 255", p);
        else pass_cnt++;
    endtask

    task automatic test_mode_change();
        logic [7:0] p;
        logic       d;
        do_reset();
        mode_in = 2'd0; scroll_en = 1'b0;
        pix(0, 0, 1'b1, p, d);
        // Mid-frame request for GRID must be ignored: (40,8) is 255 in
        // CHECKER but 0 in GRID.
        mode_in = 2'd3;
        pix(40, 8, 1'b1, p, d);
        total_cnt++;
        if (p !== 8'hFF) $display("FAIL mode_midframe: got %0d want 255", p);
        else pass_cnt++;
        // Frame start pixel (0,0) is 255 in GRID, 0 in CHECKER.
        pix(0, 0, 1'b1, p, d);
        total_cnt++;
        if (p !== 8'hFF) $display("FAIL mode_fs_bypass: got %0d want 255", p);
        else pass_cnt++;
        pix(40, 8, 1'b1, p, d);
        total_cnt++;
        if (p !== 8'h00) $display("FAIL mode_new_frame: got %0d want 0", p);
        else pass_cnt++;
        total_cnt++;
        if (frame_cnt !== 8'd2) $display("FAIL mode_frame_cnt: got %0d want 2", frame_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] p;
        logic       d;
        do_reset();
        mode_in = 2'd2; scroll_en = 1'b0;
        pix(0, 0, 1'b1, p, d);
        vga_x = 11'd100; vga_y = 11'd10; de_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (pixel_out !== 8'd100) $display("FAIL rstmid_stream: got %0d want 100", pixel_out);
        else pass_cnt++;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("reset mid-frame -> pixel_out=%0d de_out=%0b frame_cnt=%0d", pixel_out, de_out, frame_cnt);
        total_cnt++;
        if (pixel_out !== 8'd0) $display("FAIL rstmid_pixel: got %0d want 0", pixel_out);
        else pass_cnt++;
        total_cnt++;
        if (de_out !== 1'b0) $display("FAIL rstmid_de: got %0b want 0", de_out);
        else pass_cnt++;
        total_cnt++;
        if (frame_cnt !== 8'd0) $display("FAIL rstmid_frame_cnt: got %0d want 0", frame_cnt);
        else pass_cnt++;
        // Release with the FS pixel on the very first cycle; RAMP shows off.
        rst_n = 1'b1;
        scroll_en = 1'b1;
        pix(0, 0, 1'b1, p, d);
        total_cnt++;
        if (p !== 8'd4) $display("FAIL rstmid_off: got %0d want 4", p);
        else pass_cnt++;
        total_cnt++;
        if (frame_cnt !== 8'd1) $display("FAIL rstmid_fs_cnt: got %0d want 1", frame_cnt);
        else pass_cnt++;
        scroll_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] p;
        logic       d;
        logic [7:0] want;
        do_reset();
        mode_in = 2'd2; scroll_en = 1'b0;
        pix(0, 0, 1'b1, p, d);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                vga_x = 11'(10 + i); vga_y = 11'd2; de_in = 1'b1;
            end else begin
                idle_inputs();
            end
            @(posedge clk); #1;
            if (i >= 1 && i <= 3) begin
                want = 8'(10 + i - 1);
                $display("stream cycle=%0d -> pixel_out=%0d de_out=%0b", i, pixel_out, de_out);
                total_cnt++;
                if (pixel_out !== want || de_out !== 1'b1)
                    $display("FAIL b2b_cycle%0d: got pix=%0d de=%0b want pix=%0d de=1",
                             i, pixel_out, de_out, want);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mode_in = 2'd0;
        scroll_en = 1'b0;
        idle_inputs();
        test_reset();
        test_checker();
        test_scroll();
        test_bars();
        test_ramp_grid();
        test_mode_change();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
